// File: rtl/dport_regs.sv
// Shared definitions for the scanout frame controller: register indices,
// CTRL/STATUS bit positions, FSM state encoding and burst alignment.
package dport_regs;

    localparam int BURST_BYTES = 128;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_BASE     = 3'd1;
    localparam logic [2:0] REG_LEN      = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_FRAMECNT = 3'd4;
    localparam logic [2:0] REG_UNDERCNT = 3'd5;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_IRQEN = 1;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_UNDERRUN = 1;
    localparam int STAT_FLIP     = 2;
    localparam int STAT_DONE     = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/dma_frame_regs.sv
// Register file for the frame controller: control, shadow/active base,
// length, sticky W1C status bits and the registered read mux.
import dport_regs::*;

module dma_frame_regs #(
    parameter int BURST_BYTES = dport_regs::BURST_BYTES,
    parameter int CNTW        = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            regwe,
    input  logic            regre,
    input  logic [2:0]      regaddr,
    input  logic [31:0]     regwdata,
    output logic [31:0]     regrdata,
    input  logic            busy,
    input  logic            commit,
    input  logic            set_done,
    input  logic            set_underrun,
    input  logic [CNTW-1:0] framecnt,
    input  logic [CNTW-1:0] undercnt,
    output logic            enable,
    output logic [31:0]     len,
    output logic [31:0]     shadow_base,
    output logic            irq
);

    localparam logic [31:0] ALIGN_MASK = ~(32'(BURST_BYTES) - 32'd1);

    logic        irqen;
    logic [31:0] active_base;
    logic        flip_pending;
    logic        done;
    logic        underrun;
    logic [31:0] rd_mux;
    logic        wr_ctrl, wr_base, wr_len, wr_status;

    assign wr_ctrl   = regwe && (regaddr == REG_CTRL);
    assign wr_base   = regwe && (regaddr == REG_BASE);
    assign wr_len    = regwe && (regaddr == REG_LEN);
    assign wr_status = regwe && (regaddr == REG_STATUS);

    always_comb begin
        rd_mux = 32'd0;
        case (regaddr)
            REG_CTRL: begin
                rd_mux[CTRL_EN]    = enable;
                rd_mux[CTRL_IRQEN] = irqen;
            end
            REG_BASE:     rd_mux = active_base;
            REG_LEN:      rd_mux = len;
            REG_STATUS: begin
                rd_mux[STAT_BUSY]     = busy;
                rd_mux[STAT_UNDERRUN] = underrun;
                rd_mux[STAT_FLIP]     = flip_pending;
                rd_mux[STAT_DONE]     = done;
            end
            REG_FRAMECNT: rd_mux = 32'(framecnt);
            REG_UNDERCNT: rd_mux = 32'(undercnt);
            default:      rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable       <= 1'b0;
            irqen        <= 1'b0;
            shadow_base  <= 32'd0;
            active_base  <= 32'd0;
            len          <= 32'd0;
            flip_pending <= 1'b0;
            done         <= 1'b0;
            underrun     <= 1'b0;
            regrdata     <= 32'd0;
        end else begin
            if (wr_ctrl) begin
                enable <= regwdata[CTRL_EN];
                irqen  <= regwdata[CTRL_IRQEN];
            end
            if (wr_base) shadow_base <= regwdata & ALIGN_MASK;
            if (wr_len)  len         <= regwdata & ALIGN_MASK;
            // commit sees the pre-write shadow, so a same-cycle BASE write stays pending
            if (commit) active_base <= shadow_base;
            if (wr_base)     flip_pending <= 1'b1;
            else if (commit) flip_pending <= 1'b0;
            done     <= set_done     | (done     & ~(wr_status & regwdata[STAT_DONE]));
            underrun <= set_underrun | (underrun & ~(wr_status & regwdata[STAT_UNDERRUN]));
            if (regre) regrdata <= rd_mux;
        end
    end

    assign irq = irqen & (done | underrun);

endmodule

// File: rtl/dma_frame_ctl.sv
// Frame-level sequencer for the scanout DMA: restarts the DMA each vstart,
// drives its address window and tracks frame completion and underrun.
//
//   state | meaning
//   IDLE  | disabled or LEN==0, vstart ignored
//   ARM   | enabled, waiting for the first vstart
//   RUN   | frame in flight, counting dmavalid beats
//   DONE  | all beats delivered, waiting for vstart
import dport_regs::*;

module dma_frame_ctl #(
    parameter int BEAT_BYTES  = 8,
    parameter int BURST_BYTES = dport_regs::BURST_BYTES,
    parameter int CNTW        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vstart,
    input  logic        regwe,
    input  logic        regre,
    input  logic [2:0]  regaddr,
    input  logic [31:0] regwdata,
    output logic [31:0] regrdata,
    output logic        dmastart,
    output logic [31:0] addrstart,
    output logic [31:0] addrend,
    input  logic        dmavalid,
    output logic        irq
);

    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    logic [1:0]      state;
    logic [31:0]     beatcnt;
    logic [31:0]     target;
    logic [CNTW-1:0] framecnt;
    logic [CNTW-1:0] undercnt;
    logic            enable;
    logic [31:0]     len;
    logic [31:0]     shadow_base;
    logic            go, start_evt, commit, last_beat, set_underrun;

    assign go           = enable && (len != 32'd0);
    assign start_evt    = vstart && (state != ST_IDLE);
    assign commit       = start_evt && go;
    assign last_beat    = (state == ST_RUN) && dmavalid && ((beatcnt + 32'd1) == target);
    // a final beat coinciding with vstart completes the frame rather than underrunning
    assign set_underrun = start_evt && (state == ST_RUN) && !last_beat;

    dma_frame_regs #(
        .BURST_BYTES (BURST_BYTES),
        .CNTW        (CNTW)
    ) u_regs (
        .clk          (clk),
        .reset        (reset),
        .regwe        (regwe),
        .regre        (regre),
        .regaddr      (regaddr),
        .regwdata     (regwdata),
        .regrdata     (regrdata),
        .busy         (state == ST_RUN),
        .commit       (commit),
        .set_done     (last_beat),
        .set_underrun (set_underrun),
        .framecnt     (framecnt),
        .undercnt     (undercnt),
        .enable       (enable),
        .len          (len),
        .shadow_base  (shadow_base),
        .irq          (irq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            beatcnt   <= 32'd0;
            target    <= 32'd0;
            framecnt  <= '0;
            undercnt  <= '0;
            dmastart  <= 1'b0;
            addrstart <= 32'd0;
            addrend   <= 32'd0;
        end else begin
            dmastart <= 1'b0;
            if (last_beat) framecnt <= framecnt + CNTW'(1);
            if (set_underrun && (undercnt != '1)) undercnt <= undercnt + CNTW'(1);
            if ((state == ST_RUN) && dmavalid) beatcnt <= beatcnt + 32'd1;
            case (state)
                ST_IDLE: if (go) state <= ST_ARM;
                default: begin
                    if (start_evt) begin
                        if (go) begin
                            addrstart <= shadow_base;
                            addrend   <= shadow_base + len;
                            target    <= len >> BEAT_SHIFT;
                            beatcnt   <= 32'd0;
                            dmastart  <= 1'b1;
                            state     <= ST_RUN;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (last_beat) begin
                        state <= ST_DONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_frame_ctl.sv
// Directed bench for dma_frame_ctl: basic frame, flip, underrun, coincidence,
// masking/disable and mid-frame reset, with hand-computed expectations.
module tb_dma_frame_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        vstart;
    logic        regwe;
    logic        regre;
    logic [2:0]  regaddr;
    logic [31:0] regwdata;
    logic [31:0] regrdata;
    logic        dmastart;
    logic [31:0] addrstart;
    logic [31:0] addrend;
    logic        dmavalid;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    logic [31:0] rd;

    dma_frame_ctl dut (
        .clk       (clk),
        .reset     (reset),
        .vstart    (vstart),
        .regwe     (regwe),
        .regre     (regre),
        .regaddr   (regaddr),
        .regwdata  (regwdata),
        .regrdata  (regrdata),
        .dmastart  (dmastart),
        .addrstart (addrstart),
        .addrend   (addrend),
        .dmavalid  (dmavalid),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        regwe = 1'b1; regaddr = a; regwdata = d;
        @(negedge clk);
        regwe = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
        regre = 1'b1; regaddr = a;
        @(negedge clk);
        regre = 1'b0;
        d = regrdata;
    endtask

    task automatic pulse_vstart();
        vstart = 1'b1;
        @(negedge clk);
        vstart = 1'b0;
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            dmavalid = 1'b1;
            @(negedge clk);
        end
        dmavalid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; vstart = 1'b0; regwe = 1'b0; regre = 1'b0;
        regaddr = 3'd0; regwdata = 32'd0; dmavalid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_dmastart", 32'(dmastart), 32'd0);
        check_val("rst_addrstart", addrstart, 32'd0);
        check_val("rst_addrend", addrend, 32'd0);
        check_val("rst_regrdata", regrdata, 32'd0);
        check_val("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // basic frame
        reg_write(3'd1, 32'h1000_0000);
        reg_write(3'd2, 32'h0000_0800);
        reg_write(3'd0, 32'h1);
        reg_read(3'd3, rd); check_val("armed_status", rd, 32'h4);
        pulse_vstart();
        check_val("f1_dmastart", 32'(dmastart), 32'd1);
        check_val("f1_addrstart", addrstart, 32'h1000_0000);
        check_val("f1_addrend", addrend, 32'h1000_0800);
        @(negedge clk);
        check_val("f1_dmastart_one", 32'(dmastart), 32'd0);
        reg_read(3'd3, rd); check_val("f1_busy", rd, 32'h1);
        beats(255);
        reg_read(3'd3, rd); check_val("f1_255_busy", rd, 32'h1);
        beats(1);
        reg_read(3'd3, rd); check_val("f1_done", rd, 32'h8);
        reg_read(3'd4, rd); check_val("f1_framecnt", rd, 32'd1);
        check_val("f1_irq_off", 32'(irq), 32'd0);

        // flip
        reg_write(3'd3, 32'h8);
        pulse_vstart();
        check_val("f2_dmastart", 32'(dmastart), 32'd1);
        reg_write(3'd1, 32'h2000_0000);
        reg_read(3'd3, rd); check_val("flip_pending", rd, 32'h5);
        check_val("flip_addr_hold", addrstart, 32'h1000_0000);
        reg_read(3'd1, rd); check_val("flip_active_base", rd, 32'h1000_0000);
        beats(256);
        pulse_vstart();
        check_val("flip_dmastart", 32'(dmastart), 32'd1);
        check_val("flip_addrstart", addrstart, 32'h2000_0000);
        check_val("flip_addrend", addrend, 32'h2000_0800);
        reg_read(3'd3, rd); check_val("flip_status", rd, 32'h9);
        reg_write(3'd3, 32'h8);
        reg_read(3'd4, rd); check_val("flip_framecnt", rd, 32'd2);

        // underrun
        reg_write(3'd0, 32'h3);
        beats(100);
        pulse_vstart();
        check_val("ur_dmastart", 32'(dmastart), 32'd1);
        check_val("ur_irq", 32'(irq), 32'd1);
        reg_read(3'd5, rd); check_val("ur_undercnt", rd, 32'd1);
        reg_read(3'd3, rd); check_val("ur_status", rd, 32'h3);
        reg_read(3'd4, rd); check_val("ur_framecnt", rd, 32'd2);
        reg_write(3'd3, 32'h2);
        check_val("ur_irq_clr", 32'(irq), 32'd0);
        reg_read(3'd3, rd); check_val("ur_status_clr", rd, 32'h1);

        // final beat coincident with vstart
        beats(255);
        dmavalid = 1'b1; vstart = 1'b1;
        @(negedge clk);
        dmavalid = 1'b0; vstart = 1'b0;
        check_val("co_dmastart", 32'(dmastart), 32'd1);
        reg_read(3'd4, rd); check_val("co_framecnt", rd, 32'd3);
        reg_read(3'd5, rd); check_val("co_undercnt", rd, 32'd1);
        reg_read(3'd3, rd); check_val("co_status", rd, 32'h9);
        check_val("co_irq", 32'(irq), 32'd1);
        reg_write(3'd3, 32'h8);

        // LEN masking and latched target
        reg_write(3'd2, 32'h85);
        reg_read(3'd2, rd); check_val("len_mask", rd, 32'h80);
        beats(16);
        reg_read(3'd3, rd); check_val("len_latched", rd, 32'h1);
        beats(240);
        reg_read(3'd3, rd); check_val("len_old_done", rd, 32'h8);
        reg_read(3'd4, rd); check_val("len_framecnt", rd, 32'd4);
        reg_write(3'd3, 32'h8);

        // BASE write coincident with vstart
        regwe = 1'b1; regaddr = 3'd1; regwdata = 32'h3000_0000; vstart = 1'b1;
        @(negedge clk);
        regwe = 1'b0; vstart = 1'b0;
        check_val("bv_dmastart", 32'(dmastart), 32'd1);
        check_val("bv_addrstart", addrstart, 32'h2000_0000);
        check_val("bv_addrend", addrend, 32'h2000_0080);
        reg_read(3'd3, rd); check_val("bv_status", rd, 32'h5);

        // disable mid-frame
        reg_write(3'd0, 32'h0);
        beats(16);
        reg_read(3'd3, rd); check_val("dis_done", rd, 32'hC);
        reg_read(3'd4, rd); check_val("dis_framecnt", rd, 32'd5);
        pulse_vstart();
        check_val("dis_no_start", 32'(dmastart), 32'd0);
        pulse_vstart();
        check_val("dis_no_start2", 32'(dmastart), 32'd0);
        reg_read(3'd3, rd); check_val("dis_idle", rd, 32'hC);

        // reset mid-frame
        reg_write(3'd0, 32'h1);
        reg_read(3'd3, rd); check_val("re_armed", rd, 32'hC);
        pulse_vstart();
        check_val("re_dmastart", 32'(dmastart), 32'd1);
        check_val("re_addrstart", addrstart, 32'h3000_0000);
        beats(5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("mr_addrstart", addrstart, 32'd0);
        check_val("mr_addrend", addrend, 32'd0);
        check_val("mr_regrdata", regrdata, 32'd0);
        check_val("mr_irq", 32'(irq), 32'd0);
        pulse_vstart();
        check_val("mr_no_start", 32'(dmastart), 32'd0);
        reg_read(3'd0, rd); check_val("mr_ctrl", rd, 32'd0);
        reg_read(3'd1, rd); check_val("mr_base", rd, 32'd0);
        reg_read(3'd2, rd); check_val("mr_len", rd, 32'd0);
        reg_read(3'd3, rd); check_val("mr_status", rd, 32'd0);
        reg_read(3'd4, rd); check_val("mr_framecnt", rd, 32'd0);
        reg_read(3'd5, rd); check_val("mr_undercnt", rd, 32'd0);

        // unmapped index
        reg_write(3'd6, 32'hFFFF_FFFF);
        reg_read(3'd6, rd); check_val("unmapped", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
